// File: rtl/instruction_fetch_stage.sv
// IF stage: loader-writable instruction memory, combinational fetch at i_pc, and the
// IF/ID pipeline register with stall/flush plus a sticky HALT detector.
module instruction_fetch_stage #(
  parameter int unsigned NBITS         = 32,
  parameter int unsigned MEM_ADDR_BITS = 8,
  parameter logic [NBITS-1:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NBITS-1:0]         i_pc,
  input  logic                     i_enable,
  input  logic                     i_hazard_detected,
  input  logic                     i_flush,
  input  logic                     i_wr_en,
  input  logic [MEM_ADDR_BITS-1:0] i_wr_addr,
  input  logic [NBITS-1:0]         i_wr_data,
  output logic [NBITS-1:0]         o_instr,
  output logic [NBITS-1:0]         o_pc_plus4,
  output logic                     o_valid,
  output logic                     o_halt
);

  localparam int unsigned     DEPTH   = 2 ** MEM_ADDR_BITS;
  localparam logic [NBITS-1:0] PC_STEP = NBITS'(4);

  typedef enum logic {RUN, HALTED} state_t;

  state_t state_q, state_d;

  logic [NBITS-1:0] mem [DEPTH];
  logic [NBITS-1:0] rd_p0;
  logic [NBITS-1:0] pc_plus4_p0;
  logic             capture_p0;
  logic             squash_p0;
  logic             halt_fire_p0;

  logic [NBITS-1:0] instr_p1;
  logic [NBITS-1:0] pc_plus4_p1;
  logic             vld_p1;

  // Memory: loader port is independent of enable, state and reset
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Stage p0: fetch; byte offset and upper PC bits are dropped so addresses wrap
  assign rd_p0       = mem[i_pc[MEM_ADDR_BITS+1:2]];
  assign pc_plus4_p0 = i_pc + PC_STEP;

  assign capture_p0   = i_enable & ~i_hazard_detected & ~i_flush;
  assign squash_p0    = i_enable & i_flush;
  // HALT counts only when it actually moves on into ID, never when stalled or squashed
  assign halt_fire_p0 = capture_p0 & (state_q == RUN) & vld_p1 & (instr_p1 == HALT_WORD);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (halt_fire_p0) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  // Stage p1: IF/ID register; flush beats stall, halted state drains with bubbles
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      instr_p1    <= '0;
      pc_plus4_p1 <= '0;
      vld_p1      <= 1'b0;
    end else if (squash_p0) begin
      instr_p1 <= '0;
      vld_p1   <= 1'b0;
    end else if (capture_p0) begin
      if (state_q == RUN) begin
        instr_p1    <= rd_p0;
        pc_plus4_p1 <= pc_plus4_p0;
        vld_p1      <= 1'b1;
      end else begin
        instr_p1 <= '0;
        vld_p1   <= 1'b0;
      end
    end
  end

  assign o_instr    = instr_p1;
  assign o_pc_plus4 = pc_plus4_p1;
  assign o_valid    = vld_p1;
  assign o_halt     = (state_q == HALTED);

endmodule
